// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register-file widths, address type and the x0 constant
package reg_file_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN = 32;
    localparam int NUM_REGS = 32;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    localparam reg_addr_t X0 = 5'd0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting the search at prio
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW-1:0] prio_q, prio_d;
    logic [IW-1:0] idx;
    int j;
    always_comb begin
        grant = '0;
        grant_idx = '0;
        idx = '0;
        j = 0;
        // scan farthest-first so the requester closest to prio overwrites the rest
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(prio_q) + k;
            j = j >= N ? j - N : j;
            idx = IW'(j);
            if (req[idx]) begin
                grant = '0;
                grant[idx] = 1'b1;
                grant_idx = idx;
            end
        end
        prio_d = (advance && |grant) ? (grant_idx == IW'(N - 1) ? '0 : grant_idx + 1'b1) : prio_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_q <= '0;
        else prio_q <= prio_d;
    end
endmodule

// File: rtl/reg_file_wb_arbiter.sv
// reg_file_wb_arbiter: shares the register-file write port among writeback sources
// and tracks pending destinations so decode can stall on RAW hazards.
module reg_file_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN = reg_file_pkg::XLEN,
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    alloc_valid,
    input  reg_file_pkg::reg_addr_t                 alloc_reg,
    input  reg_file_pkg::reg_addr_t                 chk_reg_1,
    input  reg_file_pkg::reg_addr_t                 chk_reg_2,
    output logic                                    chk_busy_1,
    output logic                                    chk_busy_2,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  reg_file_pkg::reg_addr_t [NUM_REQ-1:0]   req_reg,
    input  logic [NUM_REQ-1:0][XLEN-1:0]            req_data,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic                                    wr_en,
    output reg_file_pkg::reg_addr_t                 wr_reg,
    output logic [XLEN-1:0]                         wr_data,
    output logic                                    sb_err
);
    import reg_file_pkg::*;
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    logic [IW-1:0] gidx;
    logic accept, waw, orphan;
    reg_addr_t sel_reg;
    logic [XLEN-1:0] sel_data;
    logic wr_en_q, wr_en_d, sb_err_q, sb_err_d;
    reg_addr_t wr_reg_q, wr_reg_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (|req_valid),
        .grant     (req_ready),
        .grant_idx (gidx)
    );
    always_comb begin
        accept = |req_ready;
        sel_reg = req_reg[gidx];
        sel_data = req_data[gidx];
        wr_en_d = accept && sel_reg != X0;
        wr_reg_d = accept ? sel_reg : wr_reg_q;
        wr_data_d = accept ? sel_data : wr_data_q;
        // a register being committed this edge is free again, so re-allocating it is legal
        waw = alloc_valid && alloc_reg != X0 && busy_q[alloc_reg] && !(wr_en_q && wr_reg_q == alloc_reg);
        orphan = accept && sel_reg != X0 && !busy_q[sel_reg];
        sb_err_d = sb_err_q || waw || orphan;
        busy_d = busy_q;
        if (wr_en_q) busy_d[wr_reg_q] = 1'b0;
        if (alloc_valid) busy_d[alloc_reg] = 1'b1;
        busy_d[0] = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= X0;
            wr_data_q <= '0;
            busy_q    <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            sb_err_q  <= sb_err_d;
        end
    end
    assign wr_en = wr_en_q;
    assign wr_reg = wr_reg_q;
    assign wr_data = wr_data_q;
    assign sb_err = sb_err_q;
    assign chk_busy_1 = busy_q[chk_reg_1];
    assign chk_busy_2 = busy_q[chk_reg_2];
endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// tb_reg_file_wb_arbiter: directed vectors with hand-computed expectations
module tb_reg_file_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic alloc_valid;
    logic [4:0] alloc_reg, chk_reg_1, chk_reg_2;
    logic chk_busy_1, chk_busy_2;
    logic [1:0] req_valid, req_ready;
    logic [1:0][4:0] req_reg;
    logic [1:0][31:0] req_data;
    logic wr_en;
    logic [4:0] wr_reg;
    logic [31:0] wr_data;
    logic sb_err;
    int n_cmp = 0;
    int n_bad = 0;
    reg_file_wb_arbiter #(.NUM_REQ(2), .XLEN(32), .NUM_REGS(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_valid (alloc_valid),
        .alloc_reg   (alloc_reg),
        .chk_reg_1   (chk_reg_1),
        .chk_reg_2   (chk_reg_2),
        .chk_busy_1  (chk_busy_1),
        .chk_busy_2  (chk_busy_2),
        .req_valid   (req_valid),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .sb_err      (sb_err)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic alloc(input logic [4:0] r);
        alloc_valid = 1'b1;
        alloc_reg = r;
        tick();
        alloc_valid = 1'b0;
    endtask
    task automatic send0(input logic [4:0] r, input logic [31:0] d);
        req_valid = 2'b01;
        req_reg[0] = r;
        req_data[0] = d;
        #1 check("ready_req0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask
    logic [1:0] rr_valid [5] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10};
    logic [4:0] rr_r0    [5] = '{5'd10, 5'd12, 5'd12, 5'd0, 5'd0};
    logic [4:0] rr_r1    [5] = '{5'd11, 5'd11, 5'd13, 5'd13, 5'd14};
    logic [1:0] rr_grant [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
    logic [4:0] rr_wreg  [5] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
    initial begin
        alloc_valid = 1'b0;
        alloc_reg = '0;
        chk_reg_1 = '0;
        chk_reg_2 = '0;
        req_valid = '0;
        req_reg = '0;
        req_data = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("post_reset_wr_en", 32'(wr_en), 32'h0);
        check("post_reset_sb_err", 32'(sb_err), 32'h0);
        chk_reg_1 = 5'd5;
        #1 check("x5_idle", 32'(chk_busy_1), 32'h0);
        alloc(5'd5);
        check("x5_alloc_busy", 32'(chk_busy_1), 32'h1);
        send0(5'd5, 32'hDEADBEEF);
        check("basic_wr_en", 32'(wr_en), 32'h1);
        check("basic_wr_reg", 32'(wr_reg), 32'd5);
        check("basic_wr_data", wr_data, 32'hDEADBEEF);
        check("basic_busy_n1", 32'(chk_busy_1), 32'h1);
        tick();
        check("basic_wr_en_off", 32'(wr_en), 32'h0);
        check("basic_busy_clr", 32'(chk_busy_1), 32'h0);
        check("basic_data_hold", wr_data, 32'hDEADBEEF);
        check("basic_sb_err", 32'(sb_err), 32'h0);
        alloc(5'd3);
        check("waw_first", 32'(sb_err), 32'h0);
        alloc(5'd3);
        check("waw_second", 32'(sb_err), 32'h1);
        tick();
        tick();
        check("waw_sticky", 32'(sb_err), 32'h1);
        alloc(5'd5);
        send0(5'd5, 32'h000000A5);
        check("pre_rst_wr_en", 32'(wr_en), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_wr_reg", 32'(wr_reg), 32'h0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_sb_err", 32'(sb_err), 32'h0);
        check("rst_busy_x5", 32'(chk_busy_1), 32'h0);
        tick();
        rst_n = 1'b1;
        send0(5'd9, 32'h00000099);
        check("orphan_wr_en", 32'(wr_en), 32'h1);
        check("orphan_wr_reg", 32'(wr_reg), 32'd9);
        check("orphan_wr_data", wr_data, 32'h99);
        check("orphan_sb_err", 32'(sb_err), 32'h1);
        tick();
        check("orphan_sticky", 32'(sb_err), 32'h1);
        do_reset();
        for (int r = 10; r <= 14; r++) alloc(5'(r));
        for (int i = 0; i < 5; i++) begin
            req_valid = rr_valid[i];
            req_reg[0] = rr_r0[i];
            req_reg[1] = rr_r1[i];
            req_data[0] = 32'h1000 + 32'(rr_r0[i]);
            req_data[1] = 32'h1000 + 32'(rr_r1[i]);
            #1 check($sformatf("rr_grant_%0d", i), 32'(req_ready), 32'(rr_grant[i]));
            tick();
            check($sformatf("rr_wr_en_%0d", i), 32'(wr_en), 32'h1);
            check($sformatf("rr_wr_reg_%0d", i), 32'(wr_reg), 32'(rr_wreg[i]));
            check($sformatf("rr_wr_data_%0d", i), wr_data, 32'h1000 + 32'(rr_wreg[i]));
        end
        req_valid = 2'b00;
        tick();
        check("rr_idle_wr_en", 32'(wr_en), 32'h0);
        check("rr_sb_err", 32'(sb_err), 32'h0);
        chk_reg_2 = 5'd0;
        alloc(5'd0);
        check("x0_busy", 32'(chk_busy_2), 32'h0);
        send0(5'd0, 32'h00001234);
        check("x0_wr_en", 32'(wr_en), 32'h0);
        check("x0_sb_err", 32'(sb_err), 32'h0);
        chk_reg_1 = 5'd7;
        alloc(5'd7);
        send0(5'd7, 32'h00000077);
        check("coll_wr_en", 32'(wr_en), 32'h1);
        alloc(5'd7);
        check("coll_busy", 32'(chk_busy_1), 32'h1);
        check("coll_sb_err", 32'(sb_err), 32'h0);
        tick();
        check("coll_busy_hold", 32'(chk_busy_1), 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_file_wb_arbiter.md
# reg_file_wb_arbiter

Shares the register file's single write port between several writeback requesters (ALU, LSU, etc.) with round-robin arbitration. Maintains a pending-write scoreboard so the decode/issue stage can stall on read-after-write hazards. Sits between the execute/memory writeback sources and `register_file`. Drives `wr_en`/`wr_reg`/`wr_data` directly.

## Interface
- `NUM_REQ`, default 2: number of writeback requesters.
- `XLEN`, default 32: data width.
- `NUM_REGS`, default 32: architectural registers; address width is log2(NUM_REGS).

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `alloc_valid` in 1: issue marks a destination register as pending.
- `alloc_reg` in 5: destination register to mark.
- `chk_reg_1` in 5: source register 1 being read by decode.
- `chk_reg_2` in 5: source register 2 being read by decode.
- `chk_busy_1` out 1: combinational; scoreboard bit of `chk_reg_1` (always 0 for x0).
- `chk_busy_2` out 1: combinational; scoreboard bit of `chk_reg_2` (always 0 for x0).
- `req_valid` in NUM_REQ: writeback request per requester.
- `req_reg` in NUM_REQ×5: destination register per requester.
- `req_data` in NUM_REQ×XLEN: write data per requester.
- `req_ready` out NUM_REQ: combinational grant, one-hot or zero.
- `wr_en` out 1: registered; to `register_file`.
- `wr_reg` out 5: registered; to `register_file`.
- `wr_data` out XLEN: registered; to `register_file`.
- `sb_err` out 1: sticky; set on a scoreboard protocol violation.

## Operation
- **Handshake.** Request i transfers at a posedge where `req_valid[i] && req_ready[i]`. At most one transfer per cycle.
  - Requester holds `req_reg` and `req_data` stable until accepted.
  - `req_ready` is never asserted without the matching `req_valid`.
- **Arbitration.** Round-robin pointer `prio`, reset to 0.
  - Grant goes to the first valid requester at or after `prio`, wrapping modulo NUM_REQ.
  - After a grant to i, `prio` becomes (i+1) mod NUM_REQ.
  - `prio` is unchanged in cycles with no grant.
- **Write stage.** An accepted request registers into `wr_en`/`wr_reg`/`wr_data` at the acceptance edge N.
  - `wr_en` = 1 only if `req_reg` != 0. A request to x0 is accepted and dropped.
  - With no acceptance, `wr_en` = 0. `wr_reg`/`wr_data` hold their last value.
- **Scoreboard.** NUM_REGS-bit `busy` vector. Bit 0 is hard-wired 0.
  - Set: at a posedge with `alloc_valid` and `alloc_reg` != 0.
  - Clear: at a posedge where `wr_en` = 1, for bit `wr_reg`. This is the same edge at which `register_file` commits the data.
  - Set and clear of the same register at the same edge: set wins. This case is a new allocation.
- **`sb_err` (sticky until reset).** Set when:
  - `alloc_valid` targets a nonzero register whose busy bit is already 1 (WAW); the bit stays 1; or
  - a request to a nonzero register is accepted while its busy bit is 0; the write still proceeds.
- **Reset.** `rst_n` low immediately forces:
  - `wr_en` = 0, `wr_reg` = 0, `wr_data` = 0;
  - `busy` = 0, `prio` = 0, `sb_err` = 0.
  - A request in flight at reset is lost; no write occurs.

## Timing
- Acceptance to `wr_en` high: 1 cycle (acceptance at edge N, `wr_en` high during cycle N+1).
- Register file commit and busy clear: edge N+1.
- `chk_busy_*` stays 1 throughout cycle N+1, so decode never reads stale data.
- `chk_busy_*` reflects `alloc` from edge M starting in cycle M+1.
- No bypass from request to `chk_busy_*`.
- Sustained throughput: one write per cycle. No bubbles while any `req_valid` is high.
- Starvation bound: a held request is granted within NUM_REQ cycles.

## Structure
- **Package `reg_file_pkg`:**
  - `REG_ADDR_W` = 5, `XLEN` = 32, `NUM_REGS` = 32;
  - `X0` = 5'd0;
  - typedef `reg_addr_t` (logic [4:0]).
  - `register_file` and this block import it.
- **Sub-module `rr_arbiter`:** parameterized by N.
  - Inputs: `clk`, `rst_n`, `req[N]`, `advance`.
  - Outputs: `grant[N]` (one-hot), `grant_idx`.
  - Owns the `prio` register.
- **Top level:** scoreboard, write-stage registers, `sb_err` logic.

## Test plan
1. **Reset.** Assert `rst_n` low mid-cycle. → Immediately `wr_en` = 0, `wr_reg` = 0, `wr_data` = 0, `sb_err` = 0, and `chk_busy` for x5 = 0.
2. **Basic write.** Alloc x5, then req0 (x5, 0xDEADBEEF) accepted at edge N. → `chk_busy_1`(x5) = 1 through cycle N+1. `wr_en` = 1, `wr_reg` = 5, `wr_data` = 0xDEADBEEF in cycle N+1. Busy bit clears at edge N+1. `register_file` x5 = 0xDEADBEEF.
3. **Round-robin.** Both requesters valid continuously, `prio` starting at 0. → Grants alternate 0, 1, 0, 1, with one write every cycle. A lone req1 afterwards is granted immediately.
4. **x0 handling.** Alloc x0, then req0 to x0 with 0x1234. → `busy[0]` stays 0. Request accepted with `wr_en` = 0. `sb_err` = 0.
5. **Set/clear collision.** Write to x7 committing at edge N while `alloc_valid` targets x7 at edge N. → x7 remains busy after edge N. `sb_err` = 0.
6. **Errors.** Alloc x3 twice without an intervening write. → `sb_err` = 1 and stays 1. After a fresh reset, a req to non-busy x9 → write still lands and `sb_err` = 1.
